// File: rtl/if_fetch_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / instruction-RAM
// arbitration slice: bus widths, chip-enable and RAM-op encodings, the
// fetch FSM state type and the sequential PC step.
package if_fetch_arbiter_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;  // InstAddrBus
   typedef logic [INST_W-1:0]      inst_t;       // InstBus

   // Reset vector and the bubble encoding shown to IF/ID when no fetch lands.
   localparam inst_addr_t RESET_PC_DEFAULT = 32'h8000_0000;
   localparam inst_t      NOP_INST_DEFAULT = 32'h0000_0000;

   // Instruction-RAM wrapper control encodings.
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;
   localparam logic ROM_OP_READ  = 1'b0;
   localparam logic ROM_OP_WRITE = 1'b1;

   // BOOT lasts exactly one cycle after reset so the first fetch is
   // issued one cycle after rst deasserts.
   typedef enum logic {
      FETCH_STATE_BOOT = 1'b0,
      FETCH_STATE_RUN  = 1'b1
   } fetch_state_e;

   localparam inst_addr_t PC_STEP = 32'd4;

   // Sequential successor of a fetch address; wraps modulo 2^32.
   function automatic inst_addr_t pc_plus4(input inst_addr_t pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/if_next_pc.sv
// PC register with the next-PC priority mux and the pending-branch latch
// that carries a taken branch across cycles in which the PC cannot move.
module if_next_pc
   import if_fetch_arbiter_pkg::*;
#(
   parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,            // fetch FSM is in RUN; PC frozen otherwise
   input  logic       flush,          // exception / ERET redirect
   input  inst_addr_t new_pc,
   input  logic       hold,           // stall or MEM owns the port: PC cannot advance
   input  logic       branch_flag,
   input  inst_addr_t branch_target,
   output inst_addr_t pc
);

   inst_addr_t pc_nxt;
   logic       br_pend;
   logic       br_pend_nxt;
   inst_addr_t br_tgt;
   inst_addr_t br_tgt_nxt;

   // Next-PC selection: flush > hold (capture branch) > pending branch >
   // live branch > sequential.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      pc_nxt      = pc;
      br_pend_nxt = br_pend;
      br_tgt_nxt  = br_tgt;
      if (run) begin
         if (flush) begin
            pc_nxt      = new_pc;
            br_pend_nxt = 1'b0;
         end else if (hold) begin
            // The branch resolved while the delay slot could not be
            // fetched; remember it and redirect once the slot is fetched.
            if (branch_flag) begin
               br_pend_nxt = 1'b1;
               br_tgt_nxt  = branch_target;
            end
         end else if (br_pend) begin
            pc_nxt      = br_tgt;
            br_pend_nxt = 1'b0;
         end else if (branch_flag) begin
            pc_nxt = branch_target;
         end else begin
            pc_nxt = pc_plus4(pc);
         end
      end
   end

   // Control state: PC and the pending flag, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         pc      <= RESET_PC;
         br_pend <= 1'b0;
      end else begin
         pc      <= pc_nxt;
         br_pend <= br_pend_nxt;
      end
   end

   // Branch target storage; meaningful only while br_pend is set.
   always_ff @(posedge clk) begin
      // NOTE: the target is pure data qualified by br_pend, so it carries no
      // reset and costs no reset routing.
      br_tgt <= br_tgt_nxt;
   end

endmodule

// File: rtl/if_fetch_arbiter.sv
// IF-stage fetch unit: owns the PC, drives the single instruction-RAM port
// and arbitrates it against MEM-stage loads/stores (MEM wins). Presents
// {pc, inst, valid} to IF/ID and requests a stall while MEM holds the port.
module if_fetch_arbiter
   import if_fetch_arbiter_pkg::*;
#(
   parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT,
   parameter inst_t      NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        mem_ack_o,
   output logic        rom_ce_o,
   output logic        rom_op_o,
   output logic [31:0] rom_addr_o,
   output logic [31:0] rom_wr_data_o,
   input  logic [31:0] rom_data_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o,
   output logic        stall_req_o
);

   fetch_state_e state;
   fetch_state_e state_nxt;
   inst_addr_t   pc;
   logic         run;
   logic         fetch_live;

   assign run = (state == FETCH_STATE_RUN);

   if_next_pc #(
      .RESET_PC (RESET_PC)
   ) u_next_pc (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .flush         (flush_i),
      .new_pc        (new_pc_i),
      .hold          (stall_i | mem_req_i),
      .branch_flag   (branch_flag_i),
      .branch_target (branch_target_i),
      .pc            (pc)
   );

   // Fetch FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= FETCH_STATE_BOOT;
      else     state <= state_nxt;
   end

   // Fetch FSM next state: BOOT always hands over to RUN after one cycle.
   always_comb begin
      state_nxt = state;
      if (state == FETCH_STATE_BOOT) state_nxt = FETCH_STATE_RUN;
   end

   // Port arbitration and IF/ID outputs, combinational from state and the
   // current-cycle MEM request.
   always_comb begin
      rom_ce_o      = CHIP_DISABLE;
      rom_op_o      = ROM_OP_READ;
      rom_addr_o    = pc;
      rom_wr_data_o = '0;
      mem_ack_o     = 1'b0;
      mem_rdata_o   = '0;
      stall_req_o   = 1'b0;
      fetch_live    = 1'b0;
      if (run) begin
         rom_ce_o = CHIP_ENABLE;
         if (mem_req_i) begin
            // MEM owns the port; IF shows a bubble and asks for a stall.
            rom_op_o      = mem_we_i ? ROM_OP_WRITE : ROM_OP_READ;
            rom_addr_o    = mem_addr_i;
            rom_wr_data_o = mem_wdata_i;
            mem_ack_o     = 1'b1;
            mem_rdata_o   = mem_we_i ? '0 : rom_data_i;
            stall_req_o   = 1'b1;
         end else begin
            fetch_live = !stall_i && !flush_i;
         end
      end
   end

   assign if_valid_o = fetch_live;
   assign if_inst_o  = fetch_live ? rom_data_i : NOP_INST;
   assign if_pc_o    = pc;

endmodule

// File: tb/tb_if_fetch_arbiter.sv
// Directed bench for if_fetch_arbiter. A driver applies one input vector per
// cycle and queues the hand-computed outputs; a monitor pops and compares
// them mid-cycle on the falling edge.
module tb_if_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i, branch_flag_i, mem_req_i, mem_we_i;
   logic [31:0] new_pc_i, branch_target_i, mem_addr_i, mem_wdata_i, rom_data_i;
   logic [31:0] mem_rdata_o, rom_addr_o, rom_wr_data_o, if_pc_o, if_inst_o;
   logic        mem_ack_o, rom_ce_o, rom_op_o, if_valid_o, stall_req_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .new_pc_i        (new_pc_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .mem_req_i       (mem_req_i),
      .mem_we_i        (mem_we_i),
      .mem_addr_i      (mem_addr_i),
      .mem_wdata_i     (mem_wdata_i),
      .mem_rdata_o     (mem_rdata_o),
      .mem_ack_o       (mem_ack_o),
      .rom_ce_o        (rom_ce_o),
      .rom_op_o        (rom_op_o),
      .rom_addr_o      (rom_addr_o),
      .rom_wr_data_o   (rom_wr_data_o),
      .rom_data_i      (rom_data_i),
      .if_pc_o         (if_pc_o),
      .if_inst_o       (if_inst_o),
      .if_valid_o      (if_valid_o),
      .stall_req_o     (stall_req_o)
   );

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        br;
      logic [31:0] br_tgt;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [31:0] rom_data;
   } vec_t;

   typedef struct packed {
      logic        skip;       // state undefined this cycle
      logic        care_rom;   // compare op/addr/wr_data
      logic        care_rdata;
      logic        ce;
      logic        op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        ack;
      logic [31:0] rdata;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
      logic        stall;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t e_boot();
      exp_t e = '0;
      e.care_rdata = 1'b1;
      e.pc         = 32'h8000_0000;
      return e;
   endfunction

   function automatic exp_t e_fetch(input logic [31:0] pc, input logic [31:0] data, input logic valid);
      exp_t e = '0;
      e.care_rom = 1'b1;
      e.ce       = 1'b1;
      e.addr     = pc;
      e.pc       = pc;
      e.valid    = valid;
      e.inst     = valid ? data : 32'h0;
      return e;
   endfunction

   function automatic exp_t e_mem(input logic [31:0] pc, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata);
      exp_t e = '0;
      e.care_rom   = 1'b1;
      e.care_rdata = 1'b1;
      e.ce         = 1'b1;
      e.op         = we;
      e.addr       = addr;
      e.wd         = wd;
      e.ack        = 1'b1;
      e.rdata      = rdata;
      e.pc         = pc;
      e.stall      = 1'b1;
      return e;
   endfunction

   // Driver: one vector per cycle, applied just after the rising edge.
   task automatic cyc(input vec_t v, input exp_t e);
      @(posedge clk);
      #1;
      rst             = v.rst;
      stall_i         = v.stall;
      flush_i         = v.flush;
      new_pc_i        = v.new_pc;
      branch_flag_i   = v.br;
      branch_target_i = v.br_tgt;
      mem_req_i       = v.mem_req;
      mem_we_i        = v.mem_we;
      mem_addr_i      = v.mem_addr;
      mem_wdata_i     = v.mem_wdata;
      rom_data_i      = v.rom_data;
      exp_q.push_back(e);
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
      vec_t v = '0;
      v.rom_data = data;
      cyc(v, e_fetch(pc, data, 1'b1));
   endtask

   // Monitor: compare the queued expectation against the settled outputs.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (!e.skip) begin
            check("rom_ce", {31'b0, rom_ce_o}, {31'b0, e.ce});
            check("mem_ack", {31'b0, mem_ack_o}, {31'b0, e.ack});
            check("stall_req", {31'b0, stall_req_o}, {31'b0, e.stall});
            check("if_valid", {31'b0, if_valid_o}, {31'b0, e.valid});
            check("if_inst", if_inst_o, e.inst);
            check("if_pc", if_pc_o, e.pc);
            if (e.care_rdata) check("mem_rdata", mem_rdata_o, e.rdata);
            if (e.care_rom) begin
               check("rom_op", {31'b0, rom_op_o}, {31'b0, e.op});
               check("rom_addr", rom_addr_o, e.addr);
               check("rom_wr_data", rom_wr_data_o, e.wd);
            end
         end
      end
   end

   initial begin
      vec_t v;
      exp_t e;
      rst = 1'b1; stall_i = 0; flush_i = 0; new_pc_i = '0; branch_flag_i = 0;
      branch_target_i = '0; mem_req_i = 0; mem_we_i = 0; mem_addr_i = '0;
      mem_wdata_i = '0; rom_data_i = '0;

      // Reset for two cycles, then one BOOT cycle.
      v = '0; v.rst = 1'b1;
      e = '0; e.skip = 1'b1;
      cyc(v, e);
      cyc(v, e_boot());
      v = '0;
      cyc(v, e_boot());

      // Sequential fetch.
      fetch(32'h8000_0000, 32'h1111_1111);
      fetch(32'h8000_0004, 32'h2222_2222);
      // Stall: same address, bubble, PC holds.
      v = '0; v.stall = 1'b1; v.rom_data = 32'h3333_3333;
      cyc(v, e_fetch(32'h8000_0008, 32'h3333_3333, 1'b0));
      fetch(32'h8000_0008, 32'h3333_3333);
      fetch(32'h8000_000C, 32'h4444_4444);

      // MEM load conflict at pc 0x80000010.
      v = '0; v.mem_req = 1'b1; v.mem_addr = 32'h8000_1000;
      v.mem_wdata = 32'hAAAA_5555; v.rom_data = 32'hDEAD_BEEF;
      cyc(v, e_mem(32'h8000_0010, 1'b0, 32'h8000_1000, 32'hAAAA_5555, 32'hDEAD_BEEF));
      fetch(32'h8000_0010, 32'h5555_5555);

      // MEM store at pc 0x80000014.
      v = '0; v.mem_req = 1'b1; v.mem_we = 1'b1; v.mem_addr = 32'h8000_1004;
      v.mem_wdata = 32'h1234_5678; v.rom_data = 32'hCAFE_F00D;
      cyc(v, e_mem(32'h8000_0014, 1'b1, 32'h8000_1004, 32'h1234_5678, 32'h0));
      fetch(32'h8000_0014, 32'h6666_6666);
      fetch(32'h8000_0018, 32'h7777_7777);
      fetch(32'h8000_001C, 32'h8888_8888);

      // Branch resolved during a two-cycle stall at pc 0x80000020.
      v = '0; v.stall = 1'b1; v.br = 1'b1; v.br_tgt = 32'h8000_0100; v.rom_data = 32'h9999_9999;
      cyc(v, e_fetch(32'h8000_0020, 32'h9999_9999, 1'b0));
      v = '0; v.stall = 1'b1; v.rom_data = 32'h9999_9999;
      cyc(v, e_fetch(32'h8000_0020, 32'h9999_9999, 1'b0));
      fetch(32'h8000_0020, 32'h9999_9999);   // delay slot, then redirect
      fetch(32'h8000_0100, 32'hA0A0_A0A0);

      // Unstalled branch: delay slot at 0x80000104, then target.
      v = '0; v.br = 1'b1; v.br_tgt = 32'h8000_0200; v.rom_data = 32'hB0B0_B0B0;
      cyc(v, e_fetch(32'h8000_0104, 32'hB0B0_B0B0, 1'b1));
      fetch(32'h8000_0200, 32'hC0C0_C0C0);

      // Build br_pend, then flush together with stall and a MEM store.
      v = '0; v.stall = 1'b1; v.br = 1'b1; v.br_tgt = 32'h8000_0300; v.rom_data = 32'hD0D0_D0D0;
      cyc(v, e_fetch(32'h8000_0204, 32'hD0D0_D0D0, 1'b0));
      v = '0; v.stall = 1'b1; v.mem_req = 1'b1; v.mem_we = 1'b1; v.mem_addr = 32'h8000_1008;
      v.mem_wdata = 32'h5A5A_5A5A; v.flush = 1'b1; v.new_pc = 32'h8000_1180; v.rom_data = 32'hE0E0_E0E0;
      cyc(v, e_mem(32'h8000_0204, 1'b1, 32'h8000_1008, 32'h5A5A_5A5A, 32'h0));
      fetch(32'h8000_1180, 32'hF0F0_F0F0);
      fetch(32'h8000_1184, 32'h0101_0101);   // pending branch was discarded

      // Plain flush during a fetch: bubble, then redirect.
      v = '0; v.flush = 1'b1; v.new_pc = 32'h8000_0040; v.rom_data = 32'h0202_0202;
      cyc(v, e_fetch(32'h8000_1188, 32'h0202_0202, 1'b0));
      fetch(32'h8000_0040, 32'h0303_0303);

      // PC wrap at the top of the address space.
      v = '0; v.flush = 1'b1; v.new_pc = 32'hFFFF_FFFC; v.rom_data = 32'h0404_0404;
      cyc(v, e_fetch(32'h8000_0044, 32'h0404_0404, 1'b0));
      fetch(32'hFFFF_FFFC, 32'h0505_0505);
      fetch(32'h0000_0000, 32'h0606_0606);

      // Reset asserted during a store cycle; MEM request still held after.
      v = '0; v.rst = 1'b1; v.mem_req = 1'b1; v.mem_we = 1'b1; v.mem_addr = 32'h8000_1010;
      v.mem_wdata = 32'h0000_0077; v.rom_data = 32'h0707_0707;
      cyc(v, e_mem(32'h0000_0004, 1'b1, 32'h8000_1010, 32'h0000_0077, 32'h0));
      v.rst = 1'b0;
      cyc(v, e_boot());
      fetch(32'h8000_0000, 32'h0808_0808);
      fetch(32'h8000_0004, 32'h0909_0909);

      // Let the monitor drain the queue, with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      check("scoreboard_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
